matrix_index_sequencer: RTL and testbench
=========================================

// Module: matrix_index_sequencer
// PURPOSE
//   Walks the element indices of matrices A, B and C for one coprocessor job and
//   issues one (row, column, type) beat at a time on a valid/ready interface.
//   Sits directly upstream of index_to_address: o_Row_Index, o_Column_Index and
//   o_Type drive its i_Row_Index, i_Column_Index and i_Type; o_Config drives its i_Config.
// PARAMETERS
//   IDX_W   8   width of row/column indices and of each dimension field
//   CFG_W   32  width of the configuration word
//   TYPE_W  3   width of the one-hot matrix type (001=A, 010=B, 100=C)
// PORTS
//   i_Clk           in   1       clock, rising edge
//   i_Rst_n         in   1       asynchronous reset, active low
//   i_Config        in   CFG_W   job config; [7:0]=lambda, [15:8]=gamma, [23:16]=mu, [31:24] passed through unused
//   i_Phase_En      in   3       phase enables: [0]=A, [1]=B, [2]=C
//   i_Start         in   1       start pulse; sampled only in IDLE
//   i_Abort         in   1       synchronous abort; returns to IDLE
//   i_Ready         in   1       downstream accepts the current beat
//   o_Valid         out  1       beat on o_Row_Index/o_Column_Index/o_Type is valid
//   o_Row_Index     out  IDX_W   row index i
//   o_Column_Index  out  IDX_W   column index j
//   o_Type          out  TYPE_W  one-hot matrix type of the current beat
//   o_Config        out  CFG_W   config latched at start, stable for the whole job
//   o_Busy          out  1       high from the cycle after start until the cycle after DONE
//   o_Done          out  1       one-cycle pulse at job completion
//   o_Beat_Count    out  16      accepted beats this job; cleared at start
// BEHAVIOUR
//   Reset (async, i_Rst_n=0): state IDLE; all outputs 0 (o_Config=0, o_Type=000).
//   States: IDLE -> PH_A -> PH_B -> PH_C -> DONE -> IDLE. All outputs are registered.
//   IDLE: on i_Start=1 at edge t: latch i_Config and i_Phase_En, clear o_Beat_Count,
//     and enter the first enabled phase with nonzero dimensions. o_Valid=1 with (0,0)
//     from cycle t+1. If no phase qualifies, go straight to DONE.
//   Phase extents (rows x cols): A = lambda x gamma, B = gamma x mu, C = lambda x mu.
//     A phase is skipped if its enable bit is 0 or either extent is 0.
//   Order is row-major: j increments first; at j=cols-1, j wraps to 0 and i increments.
//   Handshake: a beat transfers on a cycle with o_Valid && i_Ready. Without a transfer,
//     indices, type and o_Valid hold. On a transfer the next beat is presented the next
//     cycle; no bubbles inside or between phases (full throughput when i_Ready stays 1).
//   Last beat of a phase (i=rows-1, j=cols-1) transferred: the next cycle presents (0,0)
//     of the next qualifying phase, or enters DONE with o_Valid=0.
//   DONE: o_Done=1, o_Valid=0 for exactly one cycle, then IDLE. o_Busy falls on entry to IDLE.
//   o_Beat_Count increments on each transfer and saturates at 16'hFFFF; it holds after
//     DONE until the next start.
//   i_Start while not IDLE is ignored. i_Abort in any non-IDLE state: next cycle IDLE,
//     o_Valid=0, o_Busy=0, no o_Done. i_Abort takes priority over a same-cycle transfer.
//     i_Abort in IDLE has no effect, and i_Start is ignored in a cycle where i_Abort=1.
//   i_Config changes after start have no effect until the next start.
//   Dimension 255 is legal: indices reach 8'd254 and no counter wraps early.
//   Async reset mid-job clears immediately; no completion pulse is produced.
// TESTING
//   1. Config 32'h08040808 (lambda=8,gamma=8,mu=4), Phase_En=111, Ready=1 -> 64 A beats,
//      then 32 B, then 32 C, contiguous; o_Done 129 cycles after start edge; Beat_Count=128.
//   2. Same job, Ready toggling 1010... -> indices hold on Ready=0, order unchanged,
//      Beat_Count=128; first C beat is (0,0,100) after B beat (7,3,010).
//   3. Config mu=0, Phase_En=111 -> only 64 A beats, B and C skipped; Phase_En=000 ->
//      o_Done pulse at cycle t+1, zero beats.
//   4. Abort after 10 accepted A beats -> o_Valid=0 and o_Busy=0 next cycle, no o_Done;
//      a new start then begins at (0,0,001).
//   5. i_Start pulsed mid-job and i_Config changed mid-job -> no effect; o_Config stable.
//   6. Drop i_Rst_n asynchronously mid-phase -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/matrix_index_sequencer.sv
// matrix_index_sequencer
//   Walks the element indices of matrices A, B and C for one coprocessor job.
//   It presents one (row, column, type) beat at a time on a valid/ready
//   interface, and feeds index_to_address directly.
//
// Ports
//   i_Clk, i_Rst_n   clock (rising edge) and asynchronous active-low reset
//   i_Config         job config: [7:0]=lambda, [15:8]=gamma, [23:16]=mu
//   i_Phase_En       phase enables: [0]=A, [1]=B, [2]=C
//   i_Start          start pulse, honoured only in IDLE
//   i_Abort          synchronous abort back to IDLE
//   i_Ready          downstream accepts the current beat
//   o_Valid          current beat is valid
//   o_Row_Index      row index i
//   o_Column_Index   column index j
//   o_Type           one-hot matrix type (001=A, 010=B, 100=C)
//   o_Config         config latched at start
//   o_Busy           job in progress, including the DONE cycle
//   o_Done           one-cycle completion pulse
//   o_Beat_Count     accepted beats this job, saturating
module matrix_index_sequencer #(
  parameter int IDX_W  = 8,
  parameter int CFG_W  = 32,
  parameter int TYPE_W = 3
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [CFG_W-1:0]  i_Config,
  input  logic [2:0]        i_Phase_En,
  input  logic              i_Start,
  input  logic              i_Abort,
  input  logic              i_Ready,
  output logic              o_Valid,
  output logic [IDX_W-1:0]  o_Row_Index,
  output logic [IDX_W-1:0]  o_Column_Index,
  output logic [TYPE_W-1:0] o_Type,
  output logic [CFG_W-1:0]  o_Config,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [15:0]       o_Beat_Count
);

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, DONE} state_t;

  state_t            state_q, state_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [2:0]        en_q, en_d;
  logic [IDX_W-1:0]  row_q, row_d, col_q, col_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic              valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [IDX_W-1:0]  rows, cols;
  logic [2:0]        later_mask, pick;

  // Bit p is set when phase p is enabled and both of its extents are nonzero.
  function automatic logic [2:0] qualify(input logic [CFG_W-1:0] cfg,
                                         input logic [2:0] en);
    logic [IDX_W-1:0] l, g, m;
    l = cfg[IDX_W-1:0];
    g = cfg[2*IDX_W-1:IDX_W];
    m = cfg[3*IDX_W-1:2*IDX_W];
    return {en[2] && (l != '0) && (m != '0),
            en[1] && (g != '0) && (m != '0),
            en[0] && (l != '0) && (g != '0)};
  endfunction

  // Isolate the lowest set bit, i.e. the earliest phase still to run.
  function automatic logic [2:0] lowest(input logic [2:0] v);
    return v & (~v + 3'd1);
  endfunction

  function automatic state_t phase_state(input logic [2:0] p);
    case (p)
      3'b001:  return PH_A;
      3'b010:  return PH_B;
      3'b100:  return PH_C;
      default: return DONE;
    endcase
  endfunction

  // State and all registered outputs. The async reset clears everything,
  // so a job cut short by reset never produces a completion pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      en_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      type_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      en_q    <= en_d;
      row_q   <= row_d;
      col_q   <= col_d;
      type_q  <= type_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and next-output logic. Extents for the active phase come
  // from the latched config. On the last beat of a phase, the next phase is
  // the lowest qualifying one after it; when none remains, the FSM goes to DONE.
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    en_d       = en_q;
    row_d      = row_q;
    col_d      = col_q;
    type_d     = type_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    rows       = '0;
    cols       = '0;
    later_mask = 3'b000;
    pick       = 3'b000;

    case (state_q)
      PH_A: begin
        rows = cfg_q[IDX_W-1:0];
        cols = cfg_q[2*IDX_W-1:IDX_W];
        later_mask = 3'b110;
      end
      PH_B: begin
        rows = cfg_q[2*IDX_W-1:IDX_W];
        cols = cfg_q[3*IDX_W-1:2*IDX_W];
        later_mask = 3'b100;
      end
      PH_C: begin
        rows = cfg_q[IDX_W-1:0];
        cols = cfg_q[3*IDX_W-1:2*IDX_W];
      end
      default: ;
    endcase

    case (state_q)
      IDLE: begin
        if (i_Start && !i_Abort) begin
          cfg_d   = i_Config;
          en_d    = i_Phase_En;
          cnt_d   = '0;
          busy_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
          pick    = lowest(qualify(i_Config, i_Phase_En));
          state_d = phase_state(pick);
          type_d  = TYPE_W'(pick);
          valid_d = (pick != 3'b000);
          done_d  = (pick == 3'b000);
        end
      end
      PH_A, PH_B, PH_C: begin
        if (i_Abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          type_d  = '0;
          row_d   = '0;
          col_d   = '0;
        end else if (valid_q && i_Ready) begin
          if (cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
          if (col_q == cols - IDX_W'(1)) begin
            col_d = '0;
            if (row_q == rows - IDX_W'(1)) begin
              row_d   = '0;
              pick    = lowest(qualify(cfg_q, en_q) & later_mask);
              state_d = phase_state(pick);
              type_d  = TYPE_W'(pick);
              valid_d = (pick != 3'b000);
              done_d  = (pick == 3'b000);
            end else begin
              row_d = row_q + IDX_W'(1);
            end
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_Valid        = valid_q;
  assign o_Row_Index    = row_q;
  assign o_Column_Index = col_q;
  assign o_Type         = type_q;
  assign o_Config       = cfg_q;
  assign o_Busy         = busy_q;
  assign o_Done         = done_q;
  assign o_Beat_Count   = cnt_q;

endmodule

// File: tb/tb_matrix_index_sequencer.sv
// Self-checking bench for matrix_index_sequencer. A reference model pushes
// the expected beat stream into a scoreboard queue at job start. Each
// accepted beat pops the queue and is compared against it. Jobs come from a
// vector table; abort, start/abort in IDLE and async reset are hand-written.
module tb_matrix_index_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_Config = '0;
  logic [2:0]  i_Phase_En = '0;
  logic        i_Start = 1'b0;
  logic        i_Abort = 1'b0;
  logic        i_Ready = 1'b0;
  logic        o_Valid;
  logic [7:0]  o_Row_Index, o_Column_Index;
  logic [2:0]  o_Type;
  logic [31:0] o_Config;
  logic        o_Busy, o_Done;
  logic [15:0] o_Beat_Count;

  matrix_index_sequencer dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Config(i_Config), .i_Phase_En(i_Phase_En),
    .i_Start(i_Start), .i_Abort(i_Abort), .i_Ready(i_Ready), .o_Valid(o_Valid),
    .o_Row_Index(o_Row_Index), .o_Column_Index(o_Column_Index), .o_Type(o_Type),
    .o_Config(o_Config), .o_Busy(o_Busy), .o_Done(o_Done), .o_Beat_Count(o_Beat_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] row;
    logic [7:0] col;
    logic [2:0] typ;
  } beat_t;

  typedef struct {
    logic [31:0] cfg;
    logic [2:0]  en;
    bit          toggle;
    bit          disturb;
    int          exp_beats;
    int          exp_lat;
  } vec_t;

  beat_t sb[$];
  vec_t  vecs[8];
  int    checks = 0;
  int    passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: enabled phases with nonzero extents, visited in row-major order.
  task automatic pushModel(input logic [31:0] cfg, input logic [2:0] en);
    int l, g, m;
    int rows[3];
    int cols[3];
    l = int'(cfg[7:0]);
    g = int'(cfg[15:8]);
    m = int'(cfg[23:16]);
    rows[0] = l; cols[0] = g;
    rows[1] = g; cols[1] = m;
    rows[2] = l; cols[2] = m;
    for (int p = 0; p < 3; p++)
      if (en[p] && rows[p] != 0 && cols[p] != 0)
        for (int i = 0; i < rows[p]; i++)
          for (int j = 0; j < cols[p]; j++)
            sb.push_back('{row: 8'(i), col: 8'(j), typ: 3'(1 << p)});
  endtask

  task automatic compareBeat(input string name);
    beat_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL %s: extra beat (%0d,%0d,%b), expected none",
               name, o_Row_Index, o_Column_Index, o_Type);
    end else begin
      e = sb.pop_front();
      checkOutput(name, {13'b0, o_Type, o_Row_Index, o_Column_Index},
                  {13'b0, e.typ, e.row, e.col});
    end
  endtask

  // Runs one table job. Inputs change and outputs are sampled on the falling edge.
  task automatic applyStimulus(input vec_t v);
    int cyc;
    int lat;
    sb.delete();
    pushModel(v.cfg, v.en);
    @(negedge clk);
    i_Config = v.cfg; i_Phase_En = v.en; i_Start = 1'b1; i_Ready = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    cyc = 1;
    lat = -1;
    checkOutput("busy_after_start", 32'(o_Busy), 32'd1);
    while (cyc < 2000) begin
      if (o_Done) begin
        lat = cyc;
        break;
      end
      if (v.disturb && cyc == 20) begin
        i_Config = ~v.cfg;
        i_Start = 1'b1;
      end else begin
        i_Start = 1'b0;
      end
      i_Ready = v.toggle ? cyc[0] : 1'b1;
      if (o_Valid && i_Ready) compareBeat("beat");
      @(negedge clk);
      cyc++;
    end
    i_Start = 1'b0;
    if (lat < 0) begin
      checks++;
      $display("[TB] FAIL done_timeout: got no o_Done, expected one within 2000 cycles");
    end else begin
      if (v.exp_lat >= 0) checkOutput("done_latency", 32'(lat), 32'(v.exp_lat));
      checkOutput("beat_count", 32'(o_Beat_Count), 32'(v.exp_beats));
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      checkOutput("valid_in_done", 32'(o_Valid), 32'd0);
      checkOutput("config_held", o_Config, v.cfg);
      @(negedge clk);
      checkOutput("busy_after_done", 32'(o_Busy), 32'd0);
      checkOutput("done_one_cycle", 32'(o_Done), 32'd0);
      checkOutput("count_holds", 32'(o_Beat_Count), 32'(v.exp_beats));
    end
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_valid"}, 32'(o_Valid), 32'd0);
    checkOutput({name, "_busy"}, 32'(o_Busy), 32'd0);
    checkOutput({name, "_done"}, 32'(o_Done), 32'd0);
    checkOutput({name, "_beat"}, {13'b0, o_Type, o_Row_Index, o_Column_Index}, 32'd0);
    checkOutput({name, "_config"}, o_Config, 32'd0);
    checkOutput({name, "_count"}, 32'(o_Beat_Count), 32'd0);
  endtask

  initial begin
    bit seen_done;

    vecs[0] = '{cfg: 32'h08040808, en: 3'b111, toggle: 0, disturb: 0, exp_beats: 128, exp_lat: 129};
    vecs[1] = '{cfg: 32'h08040808, en: 3'b111, toggle: 1, disturb: 0, exp_beats: 128, exp_lat: -1};
    vecs[2] = '{cfg: 32'h00000808, en: 3'b111, toggle: 0, disturb: 0, exp_beats: 64,  exp_lat: 65};
    vecs[3] = '{cfg: 32'h08040808, en: 3'b000, toggle: 0, disturb: 0, exp_beats: 0,   exp_lat: 1};
    vecs[4] = '{cfg: 32'h00050203, en: 3'b101, toggle: 0, disturb: 0, exp_beats: 21,  exp_lat: 22};
    vecs[5] = '{cfg: 32'h00030200, en: 3'b010, toggle: 0, disturb: 0, exp_beats: 6,   exp_lat: 7};
    vecs[6] = '{cfg: 32'hAB040808, en: 3'b111, toggle: 0, disturb: 1, exp_beats: 128, exp_lat: 129};
    vecs[7] = '{cfg: 32'h000001FF, en: 3'b001, toggle: 0, disturb: 0, exp_beats: 255, exp_lat: 256};

    repeat (2) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      $display("[TB] vector %0d cfg=%h en=%b", k, vecs[k].cfg, vecs[k].en);
      applyStimulus(vecs[k]);
    end

    // Start and abort together in IDLE: the start is ignored.
    i_Start = 1'b1; i_Abort = 1'b1;
    @(negedge clk);
    i_Start = 1'b0; i_Abort = 1'b0;
    checkOutput("idle_abort_start_busy", 32'(o_Busy), 32'd0);
    checkOutput("idle_abort_start_valid", 32'(o_Valid), 32'd0);

    // Abort after 10 accepted A beats; the abort beats the same-cycle transfer.
    sb.delete();
    pushModel(32'h08040808, 3'b111);
    i_Config = 32'h08040808; i_Phase_En = 3'b111; i_Ready = 1'b1; i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      compareBeat("abort_prefix_beat");
      @(negedge clk);
    end
    i_Abort = 1'b1;
    @(negedge clk);
    i_Abort = 1'b0;
    checkOutput("abort_valid", 32'(o_Valid), 32'd0);
    checkOutput("abort_busy", 32'(o_Busy), 32'd0);
    checkOutput("abort_count", 32'(o_Beat_Count), 32'd10);
    seen_done = o_Done;
    repeat (5) begin
      @(negedge clk);
      seen_done = seen_done | o_Done;
    end
    checkOutput("abort_no_done", 32'(seen_done), 32'd0);
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
    checkOutput("restart_valid", 32'(o_Valid), 32'd1);
    checkOutput("restart_beat", {13'b0, o_Type, o_Row_Index, o_Column_Index}, {13'b0, 3'b001, 16'h0000});
    checkOutput("restart_count", 32'(o_Beat_Count), 32'd0);

    // Async reset mid-phase clears everything before the next clock edge.
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkAllZero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_done", 32'(o_Done), 32'd0);
    checkOutput("post_reset_busy", 32'(o_Busy), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
